drive_mode_ctrl: RTL

DRIVE_MODE_CTRL -- requirements
Module: drive_mode_ctrl

---
 rtl/drive_pkg.sv | 32 +++
 rtl/drive_mode_ctrl_if.sv | 25 ++
 rtl/timeout_counter.sv | 33 +++
 rtl/drive_mode_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared types and IR remote codes for the drive mode controller.
package drive_pkg;

  typedef enum logic [1:0] {
    ModeIdle = 2'b00,
    ModeCam  = 2'b01,
    ModeIr   = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    CamSearch = 2'b00,
    CamFollow = 2'b01,
    CamGiveup = 2'b10,
    CamPause  = 2'b11
  } cam_e;

  typedef enum logic [2:0] {
    DrvStop  = 3'b000,
    DrvLeft  = 3'b001,
    DrvRight = 3'b010,
    DrvFwd   = 3'b011
  } drive_e;

  localparam logic [7:0] CodeIdle  = 8'h10;
  localparam logic [7:0] CodeCam   = 8'h0F;
  localparam logic [7:0] CodeIr    = 8'h13;
  localparam logic [7:0] CodeFwd   = 8'h18;
  localparam logic [7:0] CodeLeft  = 8'h08;
  localparam logic [7:0] CodeRight = 8'h5A;
  localparam logic [7:0] CodeStop  = 8'h1C;

endpackage

// File: rtl/drive_mode_ctrl_if.sv
// Remote, camera and drive signals of the drive mode controller.
interface drive_mode_ctrl_if #(
    parameter int unsigned SPEED_W = 2
);
    logic               ir_valid;
    logic [7:0]         ir_code;
    logic               orange_detected;
    logic [2:0]         cam_direction;
    logic [SPEED_W-1:0] speed;
    logic [1:0]         mode;
    logic [1:0]         cam_state;
    logic [2:0]         drive_state;
    logic [SPEED_W-1:0] drive_speed;
    logic               mode_change;

    modport master (
        output ir_valid, ir_code, orange_detected, cam_direction, speed,
        input  mode, cam_state, drive_state, drive_speed, mode_change
    );

    modport slave (
        input  ir_valid, ir_code, orange_detected, cam_direction, speed,
        output mode, cam_state, drive_state, drive_speed, mode_change
    );
endinterface

// File: rtl/timeout_counter.sv
// Loadable saturating down-counter; expired flags the enabled cycle that uses the last tick.
module timeout_counter #(
    parameter int unsigned MAX_COUNT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int unsigned W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT + 1) : 1;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = W'(MAX_COUNT);
        end else if (en && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q <= W'(1));
endmodule

// File: rtl/drive_mode_ctrl.sv
// Mode selection from the IR remote plus camera-tracking FSM and manual drive with hold timeout.
module drive_mode_ctrl
    import drive_pkg::*;
#(
    parameter int unsigned LOST_CYCLES   = 16,
    parameter int unsigned SEARCH_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 64,
    parameter int unsigned SPEED_W       = 2,
    parameter int unsigned IR_SPEED      = 1
) (
    input logic              clk_50,
    input logic              reset,
    drive_mode_ctrl_if.slave bus
);
    mode_e              mode_q, mode_d;
    cam_e               cam_q, cam_d;
    drive_e             drive_q, drive_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               mode_change_q, mode_change_d;

    logic search_load, search_en, search_exp;
    logic lost_load, lost_en, lost_exp;
    logic hold_load, hold_en, hold_exp;
    logic ir_drive_cmd;

    assign ir_drive_cmd = bus.ir_valid &&
        (bus.ir_code == CodeFwd || bus.ir_code == CodeLeft || bus.ir_code == CodeRight);

    always_comb begin
        mode_d = mode_q;
        if (bus.ir_valid) begin
            case (bus.ir_code)
                CodeIdle: mode_d = ModeIdle;
                CodeCam:  mode_d = ModeCam;
                CodeIr:   mode_d = ModeIr;
                default:  mode_d = mode_q;
            endcase
        end

        cam_d = cam_q;
        if (mode_d != ModeCam) begin
            cam_d = CamPause;
        end else if (mode_q != ModeCam) begin
            // Fresh entry always searches first, even with a target already in view.
            cam_d = CamSearch;
        end else begin
            case (cam_q)
                CamSearch: begin
                    if (bus.orange_detected) cam_d = CamFollow;
                    else if (search_exp)     cam_d = CamGiveup;
                end
                CamFollow: if (lost_exp) cam_d = CamSearch;
                CamGiveup: if (bus.orange_detected) cam_d = CamFollow;
                default:   cam_d = CamSearch;
            endcase
        end

        drive_d = DrvStop;
        speed_d = '0;
        case (mode_d)
            ModeCam: begin
                speed_d = bus.speed;
                if (cam_d == CamSearch) begin
                    drive_d = DrvRight;
                end else if (cam_d == CamFollow && bus.orange_detected) begin
                    case (bus.cam_direction)
                        3'b001:  drive_d = DrvLeft;
                        3'b010:  drive_d = DrvRight;
                        3'b011:  drive_d = DrvFwd;
                        default: drive_d = DrvStop;
                    endcase
                end
            end
            ModeIr: begin
                speed_d = SPEED_W'(IR_SPEED);
                if (mode_q == ModeIr) begin
                    drive_d = drive_q;
                    if (bus.ir_valid && bus.ir_code == CodeFwd)        drive_d = DrvFwd;
                    else if (bus.ir_valid && bus.ir_code == CodeLeft)  drive_d = DrvLeft;
                    else if (bus.ir_valid && bus.ir_code == CodeRight) drive_d = DrvRight;
                    else if (bus.ir_valid && bus.ir_code == CodeStop)  drive_d = DrvStop;
                    else if (hold_exp)                                 drive_d = DrvStop;
                end
            end
            default: drive_d = DrvStop;
        endcase
        if (drive_d != DrvFwd) speed_d = '0;

        mode_change_d = (mode_d != mode_q) || (cam_d != cam_q);
    end

    assign search_load = (cam_d == CamSearch) && (cam_q != CamSearch);
    assign search_en   = (cam_q == CamSearch);
    // Any sighting while following restarts the lost-target window.
    assign lost_load   = (cam_d == CamFollow) && ((cam_q != CamFollow) || bus.orange_detected);
    assign lost_en     = (cam_q == CamFollow) && !bus.orange_detected;
    assign hold_load   = (mode_q == ModeIr) && ir_drive_cmd;
    assign hold_en     = (mode_q == ModeIr) && (drive_q != DrvStop);

    timeout_counter #(.MAX_COUNT(SEARCH_CYCLES)) u_search_cnt (
        .clk(clk_50), .reset(reset), .load(search_load), .en(search_en), .expired(search_exp)
    );

    timeout_counter #(.MAX_COUNT(LOST_CYCLES)) u_lost_cnt (
        .clk(clk_50), .reset(reset), .load(lost_load), .en(lost_en), .expired(lost_exp)
    );

    timeout_counter #(.MAX_COUNT(HOLD_CYCLES)) u_hold_cnt (
        .clk(clk_50), .reset(reset), .load(hold_load), .en(hold_en), .expired(hold_exp)
    );

    always_ff @(posedge clk_50) begin
        if (reset) begin
            mode_q        <= ModeIdle;
            cam_q         <= CamPause;
            drive_q       <= DrvStop;
            speed_q       <= '0;
            mode_change_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            cam_q         <= cam_d;
            drive_q       <= drive_d;
            speed_q       <= speed_d;
            mode_change_q <= mode_change_d;
        end
    end

    assign bus.mode        = mode_q;
    assign bus.cam_state   = cam_q;
    assign bus.drive_state = drive_q;
    assign bus.drive_speed = speed_q;
    assign bus.mode_change = mode_change_q;
endmodule
